// File: rtl/std_clk_pkg.sv
// Shared definitions for the programmable clock divider:
// the FSM state type, the smallest legal ratio, and the ratio clamp.
package std_clk_pkg;

    // Divider run state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clkdiv_state_e;

    // Smallest ratio that still gives one high and one low cycle
    localparam int unsigned CLKDIV_MIN = 2;

    // Ratios of 0 or 1 cannot form a period with both phases, so they
    // are raised to the minimum at the point a ratio is accepted.
    function automatic logic [31:0] clkdiv_clamp(input logic [31:0] n);
        logic [31:0] res;
        res = n;
        if (n < 32'(CLKDIV_MIN)) begin
            res = 32'(CLKDIV_MIN);
        end
        return res;
    endfunction

endpackage

// File: rtl/std_clk_div.sv
// Programmable integer clock divider with a registered, glitch-free
// divided clock (clk_o) and a one-cycle tick at each clk_o rising edge.
// Ratio changes are staged and only take effect on a period boundary.
//
// Build option STD_CLK_DIV_RUNTIME_EN:
//   defined   - div_i/div_vld_i/div_rdy_o handshake updates the ratio
//   undefined - ratio fixed at clamp(DIV_DEF), div_rdy_o tied low
module std_clk_div
    import std_clk_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_DEF = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_vld_i,
    output logic             div_rdy_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o
);

    // Reset ratio: truncate to the field width first, then clamp, so the
    // value loaded matches what the ratio register can actually hold.
    localparam logic [DIV_W-1:0] DIV_DEF_W = DIV_W'(DIV_DEF);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(clkdiv_clamp(32'(DIV_DEF_W)));
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    clkdiv_state_e    state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic             clk_q;
    logic             tick_q;

    logic [DIV_W-1:0] high_cur;
    logic [DIV_W-1:0] cnt_inc;
    logic             wrap;

    // Period arithmetic: the high phase takes the extra cycle of an odd
    // ratio, and the wrap cycle is the last cycle of the running period.
    always_comb begin
        high_cur = div_cur - (div_cur >> 1);
        cnt_inc  = cnt + ONE;
        wrap     = (state == RUN) && (cnt == (div_cur - ONE));
    end

`ifdef STD_CLK_DIV_RUNTIME_EN

    logic [DIV_W-1:0] div_pend;
    logic             pend_vld;
    logic             xfer;
    logic             apply_pend;

    // A staged ratio is applied at once while idle, otherwise only on the
    // wrap cycle so a running period is never shortened or stretched.
    // Only one ratio may be staged at a time.
    always_comb begin
        xfer       = div_vld_i && !pend_vld;
        apply_pend = pend_vld && ((state == IDLE) || wrap);
    end

    // Ratio staging and hand-over; reset discards any staged ratio.
    // A transfer on the wrap cycle sees pend_vld low there, so it is only
    // staged and waits for the next wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cur  <= DIV_RST;
            div_pend <= DIV_RST;
            pend_vld <= 1'b0;
        end else begin
            if (apply_pend) begin
                div_cur  <= div_pend;
                pend_vld <= 1'b0;
            end
            if (xfer) begin
                div_pend <= DIV_W'(clkdiv_clamp(32'(div_i)));
                pend_vld <= 1'b1;
            end
        end
    end

    assign div_rdy_o = !pend_vld;

`else

    logic unused_runtime_inputs;

    // Fixed ratio build: no staging registers, the ratio is a constant and
    // the handshake inputs are deliberately left without effect.
    assign div_cur               = DIV_RST;
    assign div_rdy_o             = 1'b0;
    assign unused_runtime_inputs = ^{div_i, div_vld_i};

`endif

    // Run control and phase counter. clk_q is computed from the next
    // counter value so the registered clock matches cnt < H in the same
    // cycle; a new period always opens high with a tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en_i) begin
                        state  <= RUN;
                        clk_q  <= 1'b1;
                        tick_q <= 1'b1;
                    end else begin
                        clk_q  <= 1'b0;
                        tick_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt <= '0;
                        if (en_i) begin
                            clk_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            clk_q  <= 1'b0;
                            tick_q <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt_inc;
                        clk_q  <= (cnt_inc < high_cur);
                        tick_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign busy_o = (state == RUN);

endmodule

// File: tb/tb_std_clk_div.sv
// Self-checking bench for std_clk_div. Several instances with different
// reset ratios share one set of inputs; every cycle each is compared with
// a period-level reference model, plus table vectors and hand sequences.
module tb_std_clk_div;

    localparam int DIV_W = 8;
    localparam int NI    = 5;
    localparam int DEFS [NI] = '{4, 5, 1, 0, 8};

`ifdef STD_CLK_DIV_RUNTIME_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             div_vld;
    logic [NI-1:0]    rdy_w;
    logic [NI-1:0]    clk_w;
    logic [NI-1:0]    tick_w;
    logic [NI-1:0]    busy_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: per instance, whether a period is running, the
    // cycle position inside it, the active ratio and a staged ratio.
    bit m_run [NI];
    int m_pos [NI];
    int m_n   [NI];
    bit m_pv  [NI];
    int m_pn  [NI];

    typedef struct {
        bit r;
        bit e;
        bit x_clk;
        bit x_tick;
        bit x_busy;
    } vec_t;

    vec_t vecs [14];

    bit exp_a_clk [8]  = '{0, 1, 1, 1, 0, 0, 0, 1};
    bit exp_a_rdy [8]  = '{0, 1, 1, 1, 1, 1, 1, 1};
    bit exp_b_clk [11] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    bit exp_b_tck [11] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    bit exp_n5    [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    bit exp_n2    [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    bit exp_n4    [8]  = '{1, 0, 0, 1, 1, 0, 0, 1};

    // Clock generation
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        std_clk_div #(
            .DIV_W   (DIV_W),
            .DIV_DEF (DEFS[g])
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en),
            .div_i     (div),
            .div_vld_i (div_vld),
            .div_rdy_o (rdy_w[g]),
            .clk_o     (clk_w[g]),
            .tick_o    (tick_w[g]),
            .busy_o    (busy_w[g])
        );
    end

    function automatic int clamp_ref(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Single comparison with failure report
    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Advance the model by one source-clock edge using the current inputs
    task automatic model_step(input bit r, input bit e, input bit v, input int d);
        for (int i = 0; i < NI; i++) begin
            bit xfer;
            xfer = RT && v && !m_pv[i];
            if (r) begin
                m_run[i] = 1'b0;
                m_pos[i] = 0;
                m_n[i]   = clamp_ref(DEFS[i]);
                m_pv[i]  = 1'b0;
                m_pn[i]  = 0;
            end else begin
                if (!m_run[i]) begin
                    if (m_pv[i]) begin
                        m_n[i]  = m_pn[i];
                        m_pv[i] = 1'b0;
                    end
                    m_pos[i] = 0;
                    m_run[i] = e;
                end else if (m_pos[i] == m_n[i] - 1) begin
                    if (m_pv[i]) begin
                        m_n[i]  = m_pn[i];
                        m_pv[i] = 1'b0;
                    end
                    m_pos[i] = 0;
                    m_run[i] = e;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
                if (xfer) begin
                    m_pn[i] = clamp_ref(d);
                    m_pv[i] = 1'b1;
                end
            end
        end
    endtask

    // Compare every instance with the model
    task automatic checkOutput();
        for (int i = 0; i < NI; i++) begin
            bit x_clk;
            x_clk = m_run[i] && (m_pos[i] < (m_n[i] - m_n[i] / 2));
            check_val($sformatf("model clk def%0d", DEFS[i]), 32'(clk_w[i]), 32'(x_clk));
            check_val($sformatf("model tick def%0d", DEFS[i]), 32'(tick_w[i]), 32'(m_run[i] && m_pos[i] == 0));
            check_val($sformatf("model busy def%0d", DEFS[i]), 32'(busy_w[i]), 32'(m_run[i]));
            check_val($sformatf("model rdy def%0d", DEFS[i]), 32'(rdy_w[i]), 32'(RT && !m_pv[i]));
        end
    endtask

    // Drive one cycle of inputs, step the model, sample after the edge
    task automatic applyStimulus(input bit r, input bit e, input bit v, input int d);
        rst     = r;
        en      = e;
        div_vld = v;
        div     = DIV_W'(d);
        model_step(r, e, v, d);
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        div_vld = 1'b0;
        div     = '0;

        // Ratio-4 instance: start, one full period, stop mid-period, restart, reset
        vecs[0]  = '{1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 1};
        vecs[2]  = '{0, 1, 1, 0, 1};
        vecs[3]  = '{0, 1, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 1};
        vecs[5]  = '{0, 1, 1, 1, 1};
        vecs[6]  = '{0, 1, 1, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 1, 1, 1};
        vecs[12] = '{1, 1, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0};

        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k].r, vecs[k].e, 1'b0, 0);
            check_val($sformatf("vec%0d clk", k), 32'(clk_w[0]), 32'(vecs[k].x_clk));
            check_val($sformatf("vec%0d tick", k), 32'(tick_w[0]), 32'(vecs[k].x_tick));
            check_val($sformatf("vec%0d busy", k), 32'(busy_w[0]), 32'(vecs[k].x_busy));
            check_val($sformatf("vec%0d rdy", k), 32'(rdy_w[0]), 32'(RT));
        end

        // Odd ratio and clamped ratios 0/1 from reset
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 0, 0);
            check_val("n5 clk", 32'(clk_w[1]), 32'(exp_n5[k]));
            check_val("n1 clk", 32'(clk_w[2]), 32'(exp_n2[k]));
            check_val("n0 clk", 32'(clk_w[3]), 32'(exp_n2[k]));
        end

        // Drop en at cnt=1 of ratio 8: period completes, then stays idle
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            check_val("n8 drop busy", 32'(busy_w[4]), 32'd1);
            check_val("n8 drop clk", 32'(clk_w[4]), 32'((k < 2) ? 1 : 0));
        end
        applyStimulus(0, 0, 0, 0);
        check_val("n8 stop busy", 32'(busy_w[4]), 32'd0);
        check_val("n8 stop clk", 32'(clk_w[4]), 32'd0);
        applyStimulus(0, 0, 0, 0);
        check_val("n8 idle clk", 32'(clk_w[4]), 32'd0);

        // Reassert en before the wrap: no gap between periods
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        check_val("n8 regap clk", 32'(clk_w[4]), 32'd1);
        check_val("n8 regap tick", 32'(tick_w[4]), 32'd1);
        check_val("n8 regap busy", 32'(busy_w[4]), 32'd1);

`ifdef STD_CLK_DIV_RUNTIME_EN
        // Mid-period transfer of 6 while running ratio 4
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 6);
        check_val("mid xfer rdy", 32'(rdy_w[0]), 32'd0);
        check_val("mid xfer clk", 32'(clk_w[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 0, 0);
            check_val("mid xfer clk seq", 32'(clk_w[0]), 32'(exp_a_clk[k]));
            check_val("mid xfer rdy seq", 32'(rdy_w[0]), 32'(exp_a_rdy[k]));
        end

        // Transfer exactly on the wrap cycle: old ratio runs one more period
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 11; k++) begin
            applyStimulus(0, 1, (k == 0), 6);
            check_val("wrap xfer clk", 32'(clk_w[0]), 32'(exp_b_clk[k]));
            check_val("wrap xfer tick", 32'(tick_w[0]), 32'(exp_b_tck[k]));
        end
`else
        // Fixed-ratio build: handshake inputs have no effect
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 6);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, k[0], 6);
            check_val("fixed clk", 32'(clk_w[0]), 32'(exp_n4[k]));
            check_val("fixed rdy", 32'(rdy_w[0]), 32'd0);
        end
`endif

        // Reset mid-high-phase while a ratio is (possibly) staged
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 1, 6);
        check_val("rst pend clk", 32'(clk_w[0]), 32'd1);
        check_val("rst pend rdy", 32'(rdy_w[0]), 32'd0);
        applyStimulus(1, 1, 0, 0);
        check_val("rst clk", 32'(clk_w[0]), 32'd0);
        check_val("rst busy", 32'(busy_w[0]), 32'd0);
        check_val("rst rdy", 32'(rdy_w[0]), 32'(RT));
        applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 0, 0);
            check_val("rst def clk", 32'(clk_w[0]), 32'(exp_n4[k]));
        end

        // Randomized traffic against the model
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
